// File: rtl/ahb_apb_bridge_mux_if.sv
// Bus bundle for the AHB-to-APB bridge: AHB-lite slave side plus the shared/per-slave APB side.
// The bridge uses the slave modport; the driving environment uses the master modport.
interface ahb_apb_bridge_mux_if #(
  parameter int NSLV   = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]      haddr;
  logic                   hwrite;
  logic [1:0]             htrans;
  logic [DATA_W-1:0]      hwdata;
  logic                   hsel;
  logic                   hreadyin;
  logic [DATA_W-1:0]      hrdata;
  logic                   hreadyout;
  logic                   hresp;
  logic [ADDR_W-1:0]      paddr;
  logic                   pwrite;
  logic [DATA_W-1:0]      pwdata;
  logic                   penable;
  logic [NSLV-1:0]        psel;
  logic [NSLV*DATA_W-1:0] prdata;
  logic [NSLV-1:0]        pready;
  logic [NSLV-1:0]        pslverr;

  modport slave (
    input  haddr, hwrite, htrans, hwdata, hsel, hreadyin,
    output hrdata, hreadyout, hresp,
    output paddr, pwrite, pwdata, penable, psel,
    input  prdata, pready, pslverr
  );

  modport master (
    output haddr, hwrite, htrans, hwdata, hsel, hreadyin,
    input  hrdata, hreadyout, hresp,
    input  paddr, pwrite, pwdata, penable, psel,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahb_apb_bridge_mux.sv
// AHB-lite slave to APB master bridge with N-way APB slave decode, mux and two-cycle ERROR response.
// Define APB_TIMEOUT_EN to abandon ACCESS after TMO_CYC wait cycles.
module ahb_apb_bridge_mux #(
  parameter int NSLV   = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_HI = 31,
  parameter int SEL_LO = 24,
  parameter logic [SEL_HI-SEL_LO:0] SEL_BASE = 8'hF0
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 255
`endif
) (
  input  logic                clk,
  input  logic                reset,
  ahb_apb_bridge_mux_if.slave bus
);
  localparam int SEL_W = SEL_HI - SEL_LO + 1;
  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [SEL_W-1:0] NSLV_SEL = SEL_W'(NSLV);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic [SEL_W-1:0]  sel_off;
  logic              mapped;
  logic              xfer;
  logic              hready;
  logic              cur_ready;
  logic              cur_err;
  logic              apb_active;
  logic              tmo_hit;
  logic              unused_htrans0;
  logic [DATA_W-1:0] prdata_arr [NSLV];

  // Offset wraps modulo 2^SEL_W, so addresses below SEL_BASE also decode as unmapped.
  assign sel_off        = bus.haddr[SEL_HI:SEL_LO] - SEL_BASE;
  assign mapped         = (sel_off < NSLV_SEL);
  assign cur_ready      = bus.pready[idx_q];
  assign cur_err        = bus.pslverr[idx_q];
  assign apb_active     = (state_q == SETUP) || (state_q == ACCESS);
  assign unused_htrans0 = bus.htrans[0];

  always_comb begin
    hready = 1'b0;
    case (state_q)
      IDLE, ERR2: hready = 1'b1;
      ACCESS:     hready = cur_ready & ~cur_err;
      default:    hready = 1'b0;
    endcase
  end

  assign xfer = bus.hsel & bus.hreadyin & bus.htrans[1] & hready;

  for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
    assign bus.psel[gi]   = apb_active && (idx_q == IDX_W'(gi));
    assign prdata_arr[gi] = bus.prdata[gi*DATA_W +: DATA_W];
  end

`ifdef APB_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == SETUP)
      tmo_d = '0;
    else if (state_q == ACCESS && !cur_ready)
      tmo_d = tmo_q + 8'd1;
  end

  // Fires on the ACCESS cycle that would bring the wait count to TMO_CYC.
  assign tmo_hit = (state_q == ACCESS) && !cur_ready && (tmo_q == 8'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    idx_d    = idx_q;
    pwdata_d = pwdata_q;
    if (xfer) begin
      addr_d  = bus.haddr;
      write_d = bus.hwrite;
      idx_d   = sel_off[IDX_W-1:0];
    end
    case (state_q)
      IDLE, ERR2: state_d = xfer ? (mapped ? SETUP : ERR1) : IDLE;
      SETUP: begin
        pwdata_d = bus.hwdata;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (cur_ready && cur_err)
          state_d = ERR1;
        else if (cur_ready)
          state_d = xfer ? (mapped ? SETUP : ERR1) : IDLE;
        else if (tmo_hit)
          state_d = ERR1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      pwdata_q <= pwdata_d;
    end
  end

  assign bus.hreadyout = hready;
  assign bus.hresp     = (state_q == ERR1) || (state_q == ERR2);
  assign bus.hrdata    = (state_q == ACCESS) ? prdata_arr[idx_q] : '0;
  assign bus.penable   = (state_q == ACCESS);
  assign bus.paddr     = addr_q;
  assign bus.pwrite    = write_q;
  assign bus.pwdata    = pwdata_q;
endmodule

// File: tb/tb_ahb_apb_bridge_mux.sv
// Scoreboard bench for ahb_apb_bridge_mux: AHB master driver, configurable APB slave models.
// Define APB_TIMEOUT_EN for both RTL and bench to exercise the wait-state timeout.
module tb_ahb_apb_bridge_mux;
  localparam int NSLV = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
`ifdef APB_TIMEOUT_EN
  localparam int TMO  = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ahb_apb_bridge_mux_if #(.NSLV(NSLV), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_apb_bridge_mux #(
    .NSLV(NSLV), .ADDR_W(AW), .DATA_W(DW),
    .SEL_HI(31), .SEL_LO(24), .SEL_BASE(8'hF0)
`ifdef APB_TIMEOUT_EN
    , .TMO_CYC(TMO)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // APB slave models: slave i holds pready low for wait_cfg[i] ACCESS cycles.
  int            wait_cfg  [NSLV];
  logic          err_cfg   [NSLV];
  logic [DW-1:0] rdata_cfg [NSLV];
  int            acc_cnt = 0;

  always @(posedge clk) begin
    if (bus.penable && (|bus.psel) && !(|bus.pready)) acc_cnt <= acc_cnt + 1;
    else                                               acc_cnt <= 0;
  end

  always_comb begin
    bus.pready  = '0;
    bus.pslverr = '0;
    bus.prdata  = '0;
    for (int i = 0; i < NSLV; i++) begin
      bus.pready[i]          = bus.psel[i] & bus.penable & (acc_cnt >= wait_cfg[i]);
      bus.pslverr[i]         = bus.psel[i] & bus.penable & (acc_cnt >= wait_cfg[i]) & err_cfg[i];
      bus.prdata[i*DW +: DW] = rdata_cfg[i];
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
  } stim_t;

  typedef struct {
    logic [AW-1:0]   addr;
    logic            write;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    logic            err;
    int              dph;
    logic [NSLV-1:0] psel;
  } exp_t;

  stim_t stim_q [$];
  exp_t  exp_q  [$];
  int    checks   = 0;
  int    errors   = 0;
  int    overlaps = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: data-phase length counts SETUP through the completing cycle.
  function automatic exp_t model(input stim_t s);
    exp_t       e;
    logic [7:0] off;
    off     = s.addr[31:24] - 8'hF0;
    e.addr  = s.addr;
    e.write = s.write;
    e.wdata = s.wdata;
    if (off >= 8'd3) begin
      e.err = 1'b1; e.dph = 2; e.psel = '0; e.rdata = '0;
    end else begin
      e.psel = 3'b001 << off;
`ifdef APB_TIMEOUT_EN
      if (wait_cfg[off] >= TMO) begin
        e.err = 1'b1; e.dph = 1 + TMO + 2; e.rdata = '0;
      end else
`endif
      if (err_cfg[off]) begin
        e.err = 1'b1; e.dph = 2 + wait_cfg[off] + 2; e.rdata = '0;
      end else begin
        e.err = 1'b0; e.dph = 2 + wait_cfg[off]; e.rdata = rdata_cfg[off];
      end
    end
    return e;
  endfunction

  task automatic bus_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
  endtask

  task automatic drive_addr(input stim_t s);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.haddr  = s.addr;
    bus.hwrite = s.write;
  endtask

  // Pipelined AHB master: drains stim_q, pushes expectations on acceptance, checks on completion.
  task automatic run(input int budget);
    stim_t           cur;
    exp_t            e;
    logic            have_addr   = 1'b0;
    logic            acc_pending = 1'b0;
    logic            active      = 1'b0;
    logic            done_now;
    int              cyc         = 0;
    logic [NSLV-1:0] psel_or     = '0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      #1;
      done_now = 1'b0;
      if (acc_pending) begin
        exp_q.push_back(model(cur));
        bus.hwdata  = cur.wdata;
        active      = 1'b1;
        cyc         = 0;
        psel_or     = '0;
        have_addr   = 1'b0;
        acc_pending = 1'b0;
      end
      if (active) begin
        cyc++;
        psel_or |= bus.psel;
      end
      if (active && bus.hreadyout) begin
        e = exp_q.pop_front();
        check("hresp", 32'(bus.hresp), 32'(e.err));
        check("dphase", cyc, e.dph);
        check("psel", 32'(psel_or), 32'(e.psel));
        check("hrdata", bus.hrdata, e.rdata);
        if (!e.err) begin
          check("paddr", bus.paddr, e.addr);
          check("pwrite", 32'(bus.pwrite), 32'(e.write));
          if (e.write) check("pwdata", bus.pwdata, e.wdata);
        end
        $display("xfer addr=%h write=%0d resp=%0d cycles=%0d hrdata=%h",
                 e.addr, e.write, bus.hresp, cyc, bus.hrdata);
        active   = 1'b0;
        done_now = 1'b1;
      end
      if (!have_addr && stim_q.size() > 0) begin
        cur       = stim_q.pop_front();
        have_addr = 1'b1;
        drive_addr(cur);
      end
      if (have_addr && bus.hreadyout) begin
        acc_pending = 1'b1;
        if (done_now) overlaps++;
      end
      if (!have_addr) bus_idle();
      if (!active && !have_addr && !acc_pending && stim_q.size() == 0) return;
    end
    check("run_budget_expired", 32'd1, 32'd0);
    exp_q.delete();
    stim_q.delete();
    bus_idle();
  endtask

  task automatic push(input logic [31:0] addr, input logic write, input logic [31:0] wdata);
    stim_t s;
    s.addr = addr; s.write = write; s.wdata = wdata;
    stim_q.push_back(s);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_psel"},      32'(bus.psel),      32'd0);
    check({tag, "_penable"},   32'(bus.penable),   32'd0);
    check({tag, "_hreadyout"}, 32'(bus.hreadyout), 32'd1);
    check({tag, "_hresp"},     32'(bus.hresp),     32'd0);
    check({tag, "_hrdata"},    bus.hrdata,         32'd0);
    check({tag, "_paddr"},     bus.paddr,          32'd0);
    check({tag, "_pwdata"},    bus.pwdata,         32'd0);
    check({tag, "_pwrite"},    32'(bus.pwrite),    32'd0);
  endtask

  initial begin
    stim_t s;
    for (int i = 0; i < NSLV; i++) begin
      wait_cfg[i]  = 0;
      err_cfg[i]   = 1'b0;
      rdata_cfg[i] = 32'hA5A5_0000 + 32'(i);
    end
    reset        = 1'b1;
    bus.hreadyin = 1'b1;
    bus.haddr    = '0;
    bus.hwrite   = 1'b0;
    bus.hwdata   = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("reset");

    push(32'hF100_0004, 1'b1, 32'hDEAD_BEEF);
    run(50);

    wait_cfg[2]  = 3;
    rdata_cfg[2] = 32'h1234_5678;
    push(32'hF200_0010, 1'b0, 32'h0);
    run(50);
    wait_cfg[2] = 0;

    push(32'hF000_0008, 1'b0, 32'h0);
    run(50);

    err_cfg[0] = 1'b1;
    push(32'hF000_0000, 1'b0, 32'h0);
    run(50);
    err_cfg[0] = 1'b0;
    @(negedge clk);
    #1;
    check("post_err_hresp", 32'(bus.hresp), 32'd0);

    push(32'h8000_0000, 1'b1, 32'h0BAD_0BAD);
    push(32'hF300_0000, 1'b0, 32'h0);
    push(32'hEF00_0000, 1'b0, 32'h0);
    run(60);

    overlaps = 0;
    push(32'hF000_0020, 1'b1, 32'h0000_1111);
    push(32'hF200_0024, 1'b1, 32'h0000_2222);
    run(50);
    check("b2b_overlap", overlaps, 1);

    overlaps = 0;
    push(32'h9000_0000, 1'b0, 32'h0);
    push(32'hF100_0030, 1'b1, 32'h0000_3333);
    run(50);
    check("err2_accept_overlap", overlaps, 1);

`ifdef APB_TIMEOUT_EN
    wait_cfg[1] = 1000;
`else
    wait_cfg[1] = 20;
`endif
    push(32'hF100_0040, 1'b0, 32'h0);
    run(100);

    // Reset while slave 1 holds the access in wait states.
    wait_cfg[1] = 1000;
    s.addr = 32'hF100_0008; s.write = 1'b0; s.wdata = '0;
    @(negedge clk);
    drive_addr(s);
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    #1;
    check("pre_rst_penable", 32'(bus.penable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("mid_rst");
    wait_cfg[1] = 0;

    push(32'hF100_0050, 1'b0, 32'h0);
    run(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
